// File: rtl/count_match_monitor_pkg.sv
// rtl/count_match_monitor_pkg.sv - shared types and defaults for the count match monitor
// Optional window match build: WINDOW_MATCH_EN
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    QUAL   = 2'd2,
    REPORT = 2'd3
  } mon_state_t;

  localparam int CNT_W_DEF = 128;
  localparam int HIT_W_DEF = 16;

endpackage

// File: rtl/count_match_monitor_if.sv
// rtl/count_match_monitor_if.sv - target load and event record handshakes of the monitor
// Optional window match build: WINDOW_MATCH_EN adds cfg_upper
interface count_match_monitor_if
  import count_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_target;
`ifdef WINDOW_MATCH_EN
  logic [CNT_W-1:0] cfg_upper;
`endif
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_value;
  logic             evt_dir;

`ifdef WINDOW_MATCH_EN
  modport master (output cfg_valid, cfg_target, cfg_upper, evt_ready,
                  input  cfg_ready, evt_valid, evt_value, evt_dir);
  modport slave  (input  cfg_valid, cfg_target, cfg_upper, evt_ready,
                  output cfg_ready, evt_valid, evt_value, evt_dir);
`else
  modport master (output cfg_valid, cfg_target, evt_ready,
                  input  cfg_ready, evt_valid, evt_value, evt_dir);
  modport slave  (input  cfg_valid, cfg_target, evt_ready,
                  output cfg_ready, evt_valid, evt_value, evt_dir);
`endif

endinterface

// File: rtl/count_match_monitor_cmp.sv
// rtl/count_match_monitor_cmp.sv - registered counter sample and match logic (cnt_match_cmp)
// Optional window match build: WINDOW_MATCH_EN compares against [target, upper]
module cnt_match_cmp
  import count_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_dir,
  input  logic [CNT_W-1:0] target,
`ifdef WINDOW_MATCH_EN
  input  logic [CNT_W-1:0] upper,
`endif
  output logic             match,
  output logic [CNT_W-1:0] cnt_q,
  output logic             dir_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_in;
      dir_q <= cnt_dir;
    end
  end

`ifdef WINDOW_MATCH_EN
  // An inverted window (target > upper) can never satisfy both bounds.
  assign match = (target <= cnt_q) && (cnt_q <= upper);
`else
  assign match = (cnt_q == target);
`endif

endmodule

// File: rtl/count_match_monitor.sv
// rtl/count_match_monitor.sv - fires a trigger and event record after HOLD_CYCLES consecutive count matches
// Optional window match build: WINDOW_MATCH_EN
module count_match_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HOLD_CYCLES = 4,
  parameter int HIT_W       = HIT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic                  cnt_dir,
  input  logic                  arm,
  count_match_monitor_if.slave  bus,
  output logic                  trig,
  output logic [HIT_W-1:0]      hit_count,
  output logic                  busy
);

  localparam logic [7:0] HOLD_Q = 8'(HOLD_CYCLES);

  mon_state_t       state, state_d;
  logic [7:0]       qual_cnt, qual_d;
  logic [CNT_W-1:0] target_q;
  logic             loaded;
  logic             fire;
  logic             load;
  logic             match;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;

`ifdef WINDOW_MATCH_EN
  logic [CNT_W-1:0] upper_q;
`endif

  cnt_match_cmp #(.CNT_W(CNT_W)) u_cmp (
    .clk     (clk),
    .reset   (reset),
    .cnt_in  (cnt_in),
    .cnt_dir (cnt_dir),
    .target  (target_q),
`ifdef WINDOW_MATCH_EN
    .upper   (upper_q),
`endif
    .match   (match),
    .cnt_q   (cnt_q),
    .dir_q   (dir_q)
  );

  assign bus.cfg_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_comb begin
    state_d = state;
    qual_d  = qual_cnt;
    fire    = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        qual_d = '0;
        load   = bus.cfg_valid;
        if (arm && (loaded || load)) state_d = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (match) begin
          if (HOLD_CYCLES == 1) begin
            fire = 1'b1;
          end else begin
            state_d = QUAL;
            qual_d  = 8'd1;
          end
        end
      end
      QUAL: begin
        // Disarming wins even over a sample that would complete qualification.
        if (!arm) begin
          state_d = IDLE;
          qual_d  = '0;
        end else if (match) begin
          if (qual_cnt + 8'd1 == HOLD_Q) fire = 1'b1;
          else qual_d = qual_cnt + 8'd1;
        end else begin
          state_d = ARMED;
          qual_d  = '0;
        end
      end
      REPORT: begin
        if (bus.evt_valid && bus.evt_ready) state_d = arm ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      state_d = REPORT;
      qual_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      qual_cnt      <= '0;
      target_q      <= '0;
`ifdef WINDOW_MATCH_EN
      upper_q       <= '0;
`endif
      loaded        <= 1'b0;
      trig          <= 1'b0;
      bus.evt_valid <= 1'b0;
      bus.evt_value <= '0;
      bus.evt_dir   <= 1'b0;
      hit_count     <= '0;
    end else begin
      state    <= state_d;
      qual_cnt <= qual_d;
      trig     <= fire;
      if (load) begin
        target_q <= bus.cfg_target;
`ifdef WINDOW_MATCH_EN
        upper_q  <= bus.cfg_upper;
`endif
        loaded   <= 1'b1;
      end
      if (fire) begin
        bus.evt_valid <= 1'b1;
        bus.evt_value <= cnt_q;
        bus.evt_dir   <= dir_q;
        if (!(&hit_count)) hit_count <= hit_count + 1'b1;
      end else if (bus.evt_valid && bus.evt_ready) begin
        bus.evt_valid <= 1'b0;
      end
    end
  end

endmodule
